// File: rtl/spi_slave_param_if.sv
// SPI slave bus bundle: serial pins plus the parallel tx/rx word handshake.
// The slave modport is the view of spi_slave_param; master is the view of whatever drives it.
interface spi_slave_param_if #(
    parameter int DATA_W = 8
);
    logic              cs;
    logic              sck;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              frame_active;
    logic              underrun;

    modport slave (
        input  cs, sck, mosi, tx_data, tx_valid,
        output miso, miso_oe, tx_ready, rx_data, rx_valid, frame_active, underrun
    );

    modport master (
        output cs, sck, mosi, tx_data, tx_valid,
        input  miso, miso_oe, tx_ready, rx_data, rx_valid, frame_active, underrun
    );
endinterface

// File: rtl/spi_slave_param.sv
// SPI slave, any CPOL/CPHA, DATA_W-bit MSB-first words, back-to-back within one cs frame.
// rx_valid lands SYNC_STAGES+1 clk after the final sample edge; no tx word in LOAD sends all-ones
// (sticky underrun flag compiled in by SPI_SLAVE_PARAM_UNDERRUN_EN).
module spi_slave_param #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 1,
    parameter int CPHA        = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    spi_slave_param_if.slave bus
);
    localparam int                CNT_W  = $clog2(DATA_W);
    localparam logic              L_IDLE = (CPOL != 0);
    localparam logic [CNT_W-1:0]  L_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    logic [DATA_W-1:0]      r_tx_shreg;
    logic [DATA_W-1:0]      r_rx_shreg;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_miso;
    logic [CNT_W-1:0]       r_bit_cnt;

    logic                   w_sck_s;
    logic                   w_cs_s;
    logic                   w_mosi_s;
    logic                   w_lead;
    logic                   w_trail;
    logic                   w_sample;
    logic                   w_launch;
    logic                   w_cs_fall;
    logic                   w_shifting;
    logic                   w_word_done;
    logic                   w_tx_ready;
    logic [DATA_W-1:0]      w_load_word;

    // cs chain resets to "asserted" so a cs held low across reset never looks like a fresh falling edge.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sck_sync  <= {SYNC_STAGES{L_IDLE}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= L_IDLE;
            r_cs_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], bus.sck};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi};
            r_sck_d     <= w_sck_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sck_s     = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_lead      = (r_sck_d == L_IDLE) && (w_sck_s != L_IDLE);
    assign w_trail     = (r_sck_d != L_IDLE) && (w_sck_s == L_IDLE);
    assign w_sample    = (CPHA == 0) ? w_lead : w_trail;
    assign w_launch    = (CPHA == 0) ? w_trail : w_lead;
    assign w_cs_fall   = r_cs_d && !w_cs_s;
    assign w_shifting  = (r_state == SHIFT) && !w_cs_s;
    assign w_word_done = w_shifting && w_sample && (r_bit_cnt == L_LAST);
    assign w_load_word = bus.tx_valid ? bus.tx_data : '1;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_ready  = 1'b0;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
            LOAD: begin
                w_state_nxt = SHIFT;
                w_tx_ready  = bus.tx_valid && !w_cs_s;
            end
            SHIFT:   if (w_word_done) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
        if (w_cs_s) begin
            w_state_nxt = IDLE;
        end
    end

    // CPHA=0 drives the MSB straight out of LOAD, so the launch edge that follows a word's last
    // sample (bit counter back at 0) must not shift the freshly loaded word.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_tx_shreg <= '0;
            r_rx_shreg <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_miso     <= 1'b1;
            r_bit_cnt  <= '0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (CPHA == 0) begin
                        r_miso     <= w_load_word[DATA_W-1];
                        r_tx_shreg <= {w_load_word[DATA_W-2:0], 1'b0};
                    end else begin
                        r_tx_shreg <= w_load_word;
                    end
                end
                SHIFT: begin
                    if (w_shifting && w_sample) begin
                        r_rx_shreg <= {r_rx_shreg[DATA_W-2:0], w_mosi_s};
                        r_bit_cnt  <= (r_bit_cnt == L_LAST) ? '0 : r_bit_cnt + CNT_W'(1);
                        if (r_bit_cnt == L_LAST) begin
                            r_rx_data  <= {r_rx_shreg[DATA_W-2:0], w_mosi_s};
                            r_rx_valid <= 1'b1;
                        end
                    end
                    if (w_shifting && w_launch && ((CPHA != 0) || (r_bit_cnt != '0))) begin
                        r_miso     <= r_tx_shreg[DATA_W-1];
                        r_tx_shreg <= {r_tx_shreg[DATA_W-2:0], 1'b0};
                    end
                end
                default: begin
                    r_miso    <= 1'b1;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef SPI_SLAVE_PARAM_UNDERRUN_EN
    logic r_underrun;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_underrun <= 1'b0;
        end else if (w_cs_fall) begin
            r_underrun <= 1'b0;
        end else if ((r_state == LOAD) && !bus.tx_valid && !w_cs_s) begin
            r_underrun <= 1'b1;
        end
    end

    assign bus.underrun = r_underrun;
`else
    assign bus.underrun = 1'b0;
`endif

    assign bus.miso         = r_miso;
    assign bus.miso_oe      = (r_state != IDLE);
    assign bus.frame_active = (r_state != IDLE);
    assign bus.tx_ready     = w_tx_ready;
    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
endmodule
